// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the radix-2 Booth multiplier:
//   - state_t   : control FSM states
//   - BOOTH_ADD / BOOTH_SUB : Booth pair {Q[0],Qprev} codes that modify A
//   - ext_width : internal datapath width derived from the operand width
// -----------------------------------------------------------------------------
package mult_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ADD   = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } state_t;

   // {Q[0],Qprev} = 01 ends a run of ones -> add M; 10 starts one -> subtract M
   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;

   // One guard bit lets the same signed datapath handle unsigned operands
   // after zero extension.
   function automatic int ext_width(input int width);
      return width + 1;
   endfunction

endpackage

// File: rtl/booth_datapath.sv
// -----------------------------------------------------------------------------
// booth_datapath
// Combinational next-state logic for one Booth half-step.
//   E        : internal width (operand width + 1)
//   a_i      : accumulator A
//   q_i      : multiplier register Q
//   qprev_i  : bit shifted out of Q on the previous step
//   m_i      : extended multiplicand M
//   shift_i  : 0 = add/subtract step, 1 = arithmetic right shift step
//   a_o, q_o, qprev_o : next {A,Q,Qprev}
// -----------------------------------------------------------------------------
module booth_datapath
   import mult_pkg::*;
#(
   parameter int E = 9
) (
   input  logic [E-1:0] a_i,
   input  logic [E-1:0] q_i,
   input  logic         qprev_i,
   input  logic [E-1:0] m_i,
   input  logic         shift_i,
   output logic [E-1:0] a_o,
   output logic [E-1:0] q_o,
   output logic         qprev_o
);

   // Select between the Booth add/subtract decode and the {A,Q,Qprev} shift
   always_comb begin
      a_o     = a_i;
      q_o     = q_i;
      qprev_o = qprev_i;
      if (shift_i) begin
         // A msb is replicated so the partial product keeps its sign
         a_o     = {a_i[E-1], a_i[E-1:1]};
         q_o     = {a_i[0], q_i[E-1:1]};
         qprev_o = q_i[0];
      end else begin
         case ({q_i[0], qprev_i})
            BOOTH_ADD: a_o = a_i + m_i;
            BOOTH_SUB: a_o = a_i - m_i;
            default:   a_o = a_i;
         endcase
      end
   end

endmodule

// File: rtl/booth_multiplier_n.sv
// -----------------------------------------------------------------------------
// booth_multiplier_n
// Parametrised radix-2 Booth multiplier with start/done handshake, signed or
// unsigned operands and registered two's-complement and sign-magnitude output.
//   WIDTH        : operand width (>= 2)
//   clk          : system clock
//   reset        : asynchronous active-high reset
//   valid        : start request, sampled only in IDLE
//   signed_mode  : 1 = two's-complement operands, 0 = unsigned (with valid)
//   num_1        : multiplicand
//   num_2        : multiplier
//   busy         : operation in progress (acceptance until DONE is left)
//   ready        : one-cycle completion pulse
//   mult_result  : product (two's complement in signed mode)
//   magnitude    : absolute value of the product
//   sign         : product negative (signed mode only)
// -----------------------------------------------------------------------------
module booth_multiplier_n
   import mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 valid,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     num_1,
   input  logic [WIDTH-1:0]     num_2,
   output logic                 busy,
   output logic                 ready,
   output logic [2*WIDTH-1:0]   mult_result,
   output logic [2*WIDTH-1:0]   magnitude,
   output logic                 sign
);

   localparam int E  = ext_width(WIDTH);
   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(E + 1);

   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_END = CW'(E);
   localparam logic [PW-1:0] PW_ONE  = {{(PW-1){1'b0}}, 1'b1};

   state_t           state_q;
   logic [E-1:0]     a_q;
   logic [E-1:0]     q_q;
   logic [E-1:0]     m_q;
   logic             qprev_q;
   logic [CW-1:0]    cnt_q;
   logic             mode_q;
   logic [WIDTH-1:0] op1_q;
   logic [WIDTH-1:0] op2_q;
   logic             busy_q;
   logic             ready_q;
   logic [PW-1:0]    result_q;
   logic [PW-1:0]    mag_q;
   logic             sign_q;

   logic [E-1:0]     ext1_s;
   logic [E-1:0]     ext2_s;
   logic             shift_sel_s;
   logic [E-1:0]     dp_a_s;
   logic [E-1:0]     dp_q_s;
   logic             dp_qprev_s;
   logic [CW-1:0]    cnt_d;
   logic [PW-1:0]    result_d;
   logic [PW-1:0]    mag_d;
   logic             sign_d;

   booth_datapath #(
      .E (E)
   ) u_datapath (
      .a_i     (a_q),
      .q_i     (q_q),
      .qprev_i (qprev_q),
      .m_i     (m_q),
      .shift_i (shift_sel_s),
      .a_o     (dp_a_s),
      .q_o     (dp_q_s),
      .qprev_o (dp_qprev_s)
   );

   // Operand extension, step selection and result formatting from the shifted {A,Q}
   always_comb begin
      // msb of the operand only propagates into the guard bit in signed mode
      ext1_s      = {op1_q[WIDTH-1] & mode_q, op1_q};
      ext2_s      = {op2_q[WIDTH-1] & mode_q, op2_q};
      shift_sel_s = (state_q == SHIFT);
      cnt_d       = cnt_q + CNT_ONE;
      // The true product fits in PW bits: drop the top guard bits of {A,Q}
      result_d    = {dp_a_s[WIDTH-2:0], dp_q_s};
      sign_d      = mode_q & result_d[PW-1];
      if (sign_d) begin
         mag_d = ~result_d + PW_ONE;
      end else begin
         mag_d = result_d;
      end
   end

   // Control FSM, Booth registers, iteration counter and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         a_q      <= {E{1'b0}};
         q_q      <= {E{1'b0}};
         m_q      <= {E{1'b0}};
         qprev_q  <= 1'b0;
         cnt_q    <= {CW{1'b0}};
         mode_q   <= 1'b0;
         op1_q    <= {WIDTH{1'b0}};
         op2_q    <= {WIDTH{1'b0}};
         busy_q   <= 1'b0;
         ready_q  <= 1'b0;
         result_q <= {PW{1'b0}};
         mag_q    <= {PW{1'b0}};
         sign_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               ready_q <= 1'b0;
               if (valid) begin
                  op1_q   <= num_1;
                  op2_q   <= num_2;
                  mode_q  <= signed_mode;
                  busy_q  <= 1'b1;
                  state_q <= LOAD;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            LOAD: begin
               a_q     <= {E{1'b0}};
               q_q     <= ext2_s;
               m_q     <= ext1_s;
               qprev_q <= 1'b0;
               cnt_q   <= {CW{1'b0}};
               state_q <= ADD;
            end
            ADD: begin
               a_q     <= dp_a_s;
               q_q     <= dp_q_s;
               qprev_q <= dp_qprev_s;
               state_q <= SHIFT;
            end
            SHIFT: begin
               a_q     <= dp_a_s;
               q_q     <= dp_q_s;
               qprev_q <= dp_qprev_s;
               cnt_q   <= cnt_d;
               if (cnt_d == CNT_END) begin
                  result_q <= result_d;
                  mag_q    <= mag_d;
                  sign_q   <= sign_d;
                  ready_q  <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  state_q  <= ADD;
               end
            end
            DONE: begin
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign ready       = ready_q;
   assign mult_result = result_q;
   assign magnitude   = mag_q;
   assign sign        = sign_q;

endmodule

// File: tb/tb_booth_multiplier_n.sv
// -----------------------------------------------------------------------------
// tb_booth_multiplier_n
// Scoreboard bench for booth_multiplier_n at WIDTH=8 and WIDTH=4. Drivers push
// hand-computed results with the edge at which ready must be seen; monitors pop
// and compare whenever ready is high.
// -----------------------------------------------------------------------------
module tb_booth_multiplier_n;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic        valid8 = 1'b0;
   logic        sm8 = 1'b0;
   logic [7:0]  n1_8 = 8'd0;
   logic [7:0]  n2_8 = 8'd0;
   logic        busy8;
   logic        ready8;
   logic [15:0] res8;
   logic [15:0] mag8;
   logic        sign8;

   logic        valid4 = 1'b0;
   logic        sm4 = 1'b0;
   logic [3:0]  n1_4 = 4'd0;
   logic [3:0]  n2_4 = 4'd0;
   logic        busy4;
   logic        ready4;
   logic [7:0]  res4;
   logic [7:0]  mag4;
   logic        sign4;

   typedef struct {
      logic [15:0] res;
      logic [15:0] mag;
      logic        sgn;
      int          at;
   } exp_t;

   exp_t q8[$];
   exp_t q4[$];

   int edge_cnt = 0;
   int total = 0;
   int bad = 0;

   booth_multiplier_n #(.WIDTH(8)) dut8 (
      .clk (clk), .reset (reset), .valid (valid8), .signed_mode (sm8),
      .num_1 (n1_8), .num_2 (n2_8), .busy (busy8), .ready (ready8),
      .mult_result (res8), .magnitude (mag8), .sign (sign8)
   );

   booth_multiplier_n #(.WIDTH(4)) dut4 (
      .clk (clk), .reset (reset), .valid (valid4), .signed_mode (sm4),
      .num_1 (n1_4), .num_2 (n2_4), .busy (busy4), .ready (ready4),
      .mult_result (res4), .magnitude (mag4), .sign (sign4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h (edge %0d)", name, act, req, edge_cnt);
      end
   endtask

   // WIDTH=8 monitor
   always @(negedge clk) begin
      exp_t e;
      if (ready8 === 1'b1) begin
         if (q8.size() == 0) begin
            check("ready8_unexpected", {31'd0, ready8}, 32'd0);
         end else begin
            e = q8.pop_front();
            check("res8", {16'd0, res8}, {16'd0, e.res});
            check("mag8", {16'd0, mag8}, {16'd0, e.mag});
            check("sign8", {31'd0, sign8}, {31'd0, e.sgn});
            check("latency8", edge_cnt, e.at);
         end
      end
   end

   // WIDTH=4 monitor
   always @(negedge clk) begin
      exp_t e;
      if (ready4 === 1'b1) begin
         if (q4.size() == 0) begin
            check("ready4_unexpected", {31'd0, ready4}, 32'd0);
         end else begin
            e = q4.pop_front();
            check("res4", {24'd0, res4}, {24'd0, e.res[7:0]});
            check("mag4", {24'd0, mag4}, {24'd0, e.mag[7:0]});
            check("sign4", {31'd0, sign4}, {31'd0, e.sgn});
            check("latency4", edge_cnt, e.at);
         end
      end
   end

   task automatic issue8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] res, input logic [15:0] mag, input logic sg);
      exp_t e;
      @(negedge clk);
      n1_8 = a; n2_8 = b; sm8 = sm; valid8 = 1'b1;
      e.res = res; e.mag = mag; e.sgn = sg; e.at = edge_cnt + 20;
      q8.push_back(e);
      @(negedge clk);
      // scramble inputs after acceptance: they must have no effect
      valid8 = 1'b0; n1_8 = ~a; n2_8 = 8'h33; sm8 = ~sm;
      check("busy8_after_accept", {31'd0, busy8}, 32'd1);
   endtask

   task automatic issue4(input logic sm, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] res, input logic [7:0] mag, input logic sg);
      exp_t e;
      @(negedge clk);
      n1_4 = a; n2_4 = b; sm4 = sm; valid4 = 1'b1;
      e.res = {8'd0, res}; e.mag = {8'd0, mag}; e.sgn = sg; e.at = edge_cnt + 12;
      q4.push_back(e);
      @(negedge clk);
      valid4 = 1'b0; n1_4 = ~a; n2_4 = 4'h5; sm4 = ~sm;
      check("busy4_after_accept", {31'd0, busy4}, 32'd1);
   endtask

   task automatic drain8();
      for (int i = 0; i < 80; i++) begin
         if (q8.size() == 0) break;
         @(negedge clk);
      end
      check("drain8_pending", 32'(q8.size()), 32'd0);
      q8.delete();
      @(negedge clk);
   endtask

   task automatic drain4();
      for (int i = 0; i < 80; i++) begin
         if (q4.size() == 0) break;
         @(negedge clk);
      end
      check("drain4_pending", 32'(q4.size()), 32'd0);
      q4.delete();
      @(negedge clk);
   endtask

   initial begin
      int   c;
      exp_t e;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_busy8", {31'd0, busy8}, 32'd0);
      check("rst_ready8", {31'd0, ready8}, 32'd0);
      check("rst_res8", {16'd0, res8}, 32'd0);
      check("rst_mag8", {16'd0, mag8}, 32'd0);
      check("rst_sign8", {31'd0, sign8}, 32'd0);
      check("rst_res4", {24'd0, res4}, 32'd0);
      reset = 1'b0;

      // WIDTH=8 directed vectors
      issue8(1'b1, 8'h07, 8'hFD, 16'hFFEB, 16'h0015, 1'b1); drain8();
      issue8(1'b1, 8'h80, 8'h80, 16'h4000, 16'h4000, 1'b0); drain8();
      issue8(1'b1, 8'h80, 8'h7F, 16'hC080, 16'h3F80, 1'b1); drain8();
      issue8(1'b0, 8'hFF, 8'hFF, 16'hFE01, 16'hFE01, 1'b0); drain8();
      issue8(1'b0, 8'h80, 8'h02, 16'h0100, 16'h0100, 1'b0); drain8();
      issue8(1'b0, 8'hFD, 8'h07, 16'h06EB, 16'h06EB, 1'b0); drain8();

      // 5 x 6 with ignored valid pulses, then back-to-back start after DONE
      @(negedge clk);
      c = edge_cnt;
      n1_8 = 8'd5; n2_8 = 8'd6; sm8 = 1'b0; valid8 = 1'b1;
      e.res = 16'd30; e.mag = 16'd30; e.sgn = 1'b0; e.at = c + 20;
      q8.push_back(e);
      @(negedge clk);
      valid8 = 1'b0;
      while (edge_cnt < c + 3) @(negedge clk);
      n1_8 = 8'd9; n2_8 = 8'd9; valid8 = 1'b1;
      @(negedge clk);
      valid8 = 1'b0;
      while (edge_cnt < c + 10) @(negedge clk);
      valid8 = 1'b1;
      @(negedge clk);
      valid8 = 1'b0;
      while (edge_cnt < c + 20) @(negedge clk);
      // held through DONE (ignored) into IDLE (accepted)
      n1_8 = 8'd2; n2_8 = 8'd3; valid8 = 1'b1;
      e.res = 16'd6; e.mag = 16'd6; e.sgn = 1'b0; e.at = c + 41;
      q8.push_back(e);
      while (edge_cnt < c + 22) @(negedge clk);
      valid8 = 1'b0;
      drain8();

      // WIDTH=4 directed vectors
      issue4(1'b1, 4'h8, 4'h7, 8'hC8, 8'h38, 1'b1); drain4();
      issue4(1'b1, 4'h8, 4'h8, 8'h40, 8'h40, 1'b0); drain4();
      issue4(1'b0, 4'hF, 4'hF, 8'hE1, 8'hE1, 1'b0); drain4();

      // Abort 100 x 100 with reset nine edges after acceptance
      @(negedge clk);
      c = edge_cnt;
      n1_8 = 8'd100; n2_8 = 8'd100; sm8 = 1'b0; valid8 = 1'b1;
      @(negedge clk);
      valid8 = 1'b0;
      while (edge_cnt < c + 10) @(negedge clk);
      check("busy8_mid_op", {31'd0, busy8}, 32'd1);
      reset = 1'b1;
      #1;
      check("abort_busy8", {31'd0, busy8}, 32'd0);
      check("abort_ready8", {31'd0, ready8}, 32'd0);
      check("abort_res8", {16'd0, res8}, 32'd0);
      check("abort_mag8", {16'd0, mag8}, 32'd0);
      check("abort_sign8", {31'd0, sign8}, 32'd0);
      check("abort_res4", {24'd0, res4}, 32'd0);
      check("abort_mag4", {24'd0, mag4}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (25) @(negedge clk);
      check("abort_idle_busy8", {31'd0, busy8}, 32'd0);

      issue8(1'b0, 8'd3, 8'd4, 16'd12, 16'd12, 1'b0); drain8();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
